// File: rtl/l4_weight_reader_if.sv
// Weight reader bus bundle: burst request, ROM port and beat output stream.
// master = the reader, slave = requester/ROM/consumer side.
interface l4_weight_reader_if #(
    parameter int DW    = 9,
    parameter int LANES = 16,
    parameter int AW    = 6
);
    logic                       start;
    logic [AW-1:0]              base;
    logic [2:0]                 beats;
    logic [AW-1:0]              rom_addr;
    logic [LANES-1:0][DW-1:0]   rom_dout;
    logic [LANES-1:0][DW-1:0]   out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;
    logic                       busy;
    logic                       done;

    modport master (
        input  start, base, beats, rom_dout, out_ready,
        output rom_addr, out_data, out_valid, out_last, busy, done
    );

    modport slave (
        output start, base, beats, rom_dout, out_ready,
        input  rom_addr, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/l4_weight_reader.sv
// Burst reader for the layer-4 weight ROM: issues up to four LANES-wide reads
// and presents each line as a held valid/ready beat.

module l4_weight_reader_lane #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= d;
    end
endmodule

module l4_weight_reader #(
    parameter int DW    = 9,
    parameter int LANES = 16,
    parameter int AW    = 6
) (
    input logic               clk,
    input logic               rst_n,
    l4_weight_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, LATCH, PRESENT} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic [2:0]               rem_q, rem_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic                     done_q, done_d;
    logic                     latch_en;
    logic [2:0]               beats_sat;
    logic [LANES-1:0][DW-1:0] data_q;

    assign beats_sat = (bus.beats > 3'd4) ? 3'd4 : bus.beats;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        valid_d  = valid_q;
        last_d   = last_q;
        done_d   = 1'b0;
        latch_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // An empty burst still acknowledges with done, but never touches the ROM.
                    if (beats_sat == 3'd0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = bus.base;
                        rem_d   = beats_sat;
                        state_d = ADDR;
                    end
                end
            end
            ADDR: state_d = LATCH;
            LATCH: begin
                latch_en = 1'b1;
                valid_d  = 1'b1;
                last_d   = (rem_q == 3'd1);
                state_d  = PRESENT;
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    if (rem_q > 3'd1) begin
                        addr_d  = addr_q + AW'(LANES);
                        rem_d   = rem_q - 3'd1;
                        state_d = ADDR;
                    end else begin
                        last_d  = 1'b0;
                        rem_d   = 3'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat data lives only in the lane registers and survives past the burst.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        l4_weight_reader_lane #(.DW(DW)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (latch_en),
            .d     (bus.rom_dout[i]),
            .q     (data_q[i])
        );
    end

    assign bus.rom_addr  = addr_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_l4_weight_reader.sv
// Directed bench for l4_weight_reader with a synchronous ROM model and a beat scoreboard.
module tb_l4_weight_reader;
    localparam int DW    = 9;
    localparam int LANES = 16;
    localparam int AW    = 6;

    typedef logic [LANES-1:0][DW-1:0] line_t;
    typedef struct {
        logic [AW-1:0] addr;
        line_t         data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   t0 = 0;
    exp_t sb[$];
    logic [DW-1:0] rom [0:(1<<AW)-1];

    l4_weight_reader_if #(.DW(DW), .LANES(LANES), .AW(AW)) bus ();

    l4_weight_reader #(.DW(DW), .LANES(LANES), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic line_t rom_line(input logic [AW-1:0] a);
        line_t l;
        for (int i = 0; i < LANES; i++) l[i] = rom[a + AW'(i)];
        return l;
    endfunction

    always @(posedge clk) bus.rom_dout <= rom_line(bus.rom_addr);

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every accepted beat must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.done) done_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                check("beat_pending", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("beat_addr", bus.rom_addr, e.addr);
                    check("beat_data", bus.out_data, e.data);
                    check("beat_last", bus.out_last, e.last);
                end
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [2:0] n, input bit push);
        int ne;
        logic [AW-1:0] a;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base = b; bus.beats = n;
        if (push) begin
            ne = (n > 3'd4) ? 4 : int'(n);
            for (int k = 0; k < ne; k++) begin
                a = b + AW'(LANES * k);
                sb.push_back('{addr: a, data: rom_line(a), last: (k == ne - 1)});
            end
        end
        @(posedge clk); #1;
        t0 = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int el);
        el = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy) begin el = cyc - t0; break; end
        end
        check(tag, bus.busy, 0);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        check(tag, bus.out_valid, 1);
    endtask

    task automatic pulse_ready();
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
    endtask

    initial begin
        int   el, d0;
        exp_t e;
        line_t held;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.base = '0; bus.beats = '0; bus.out_ready = 1'b0;
        for (int i = 0; i < (1 << AW); i++) rom[i] = DW'($urandom);
        repeat (2) @(negedge clk);
        check("rst_addr",  bus.rom_addr, 0);
        check("rst_data",  bus.out_data, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_last",  bus.out_last, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Full 4-beat burst from 0 with ready held high: latency and beat period.
        bus.out_ready = 1'b1;
        d0 = done_cnt;
        do_start(6'd0, 3'd4, 1'b1);
        @(negedge clk); check("lat_e0_busy", bus.busy, 1); check("lat_e0_valid", bus.out_valid, 0);
        @(negedge clk); check("lat_e1_valid", bus.out_valid, 0);
        @(negedge clk); check("lat_e2_valid", bus.out_valid, 1);
        wait_idle("b4_timeout", el);
        check("b4_cycles", el, 12);
        check("b4_drained", sb.size(), 0);
        check("b4_done", done_cnt - d0, 1);
        check("b4_data_retained", bus.out_data, rom_line(6'd48));
        check("b4_last_clear", bus.out_last, 0);

        // Address wrap 48 -> 0.
        d0 = done_cnt;
        do_start(6'd48, 3'd2, 1'b1);
        wait_idle("wrap_timeout", el);
        check("wrap_cycles", el, 6);
        check("wrap_drained", sb.size(), 0);
        check("wrap_done", done_cnt - d0, 1);

        // beats=7 clamps to 4.
        do_start(6'd0, 3'd7, 1'b1);
        wait_idle("clamp_timeout", el);
        check("clamp_cycles", el, 12);
        check("clamp_drained", sb.size(), 0);

        // Back-pressure on beat 2: outputs and address held.
        bus.out_ready = 1'b0;
        d0 = done_cnt;
        do_start(6'd0, 3'd4, 1'b1);
        wait_valid("stall_b1_timeout");
        pulse_ready();
        wait_valid("stall_b2_timeout");
        e = sb[0];
        held = bus.out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.out_data, held);
            check("stall_addr", bus.rom_addr, e.addr);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_idle("stall_timeout", el);
        check("stall_drained", sb.size(), 0);
        check("stall_done", done_cnt - d0, 1);

        // Zero-beat request.
        d0 = done_cnt;
        do_start(6'd16, 3'd0, 1'b0);
        @(negedge clk);
        check("zero_busy0", bus.busy, 0);
        check("zero_done0", bus.done, 1);
        check("zero_valid0", bus.out_valid, 0);
        @(negedge clk);
        check("zero_busy1", bus.busy, 0);
        check("zero_done1", bus.done, 0);
        check("zero_done_cnt", done_cnt - d0, 1);

        // Start during a burst is ignored.
        d0 = done_cnt;
        do_start(6'd32, 3'd2, 1'b1);
        @(posedge clk); #1 bus.start = 1'b1; bus.base = 6'd0; bus.beats = 3'd4;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_idle("ign_timeout", el);
        check("ign_cycles", el, 6);
        check("ign_drained", sb.size(), 0);
        check("ign_done", done_cnt - d0, 1);
        repeat (3) begin @(negedge clk); check("ign_stay_idle", bus.busy, 0); end

        // Asynchronous reset while beat 2 is presented.
        bus.out_ready = 1'b0;
        do_start(6'd0, 3'd4, 1'b1);
        wait_valid("rst_b1_timeout");
        pulse_ready();
        wait_valid("rst_b2_timeout");
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("arst_addr",  bus.rom_addr, 0);
        check("arst_data",  bus.out_data, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_last",  bus.out_last, 0);
        check("arst_busy",  bus.busy, 0);
        check("arst_done",  bus.done, 0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        do_start(6'd16, 3'd1, 1'b1);
        wait_idle("post_rst_timeout", el);
        check("post_rst_cycles", el, 3);
        check("post_rst_drained", sb.size(), 0);
        check("post_rst_done", done_cnt - d0, 1);
        check("post_rst_data", bus.out_data, rom_line(6'd16));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/l4_weight_reader.md
L4_WEIGHT_READER -- requirements
Module: l4_weight_reader

Interface
REQ-001 SHALL have parameter DW, default 9, meaning weight word width in bits.
REQ-002 SHALL have parameter LANES, default 16, meaning words returned per ROM read.
REQ-003 SHALL have parameter AW, default 6, meaning ROM address width (64 words).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a read burst.
REQ-007 SHALL have port base  input  AW  first ROM address of the burst, sampled with start.
REQ-008 SHALL have port beats  input  3  beat count 0..4, sampled with start.
REQ-009 SHALL have port rom_addr  output  AW  registered address driven to the weight ROM.
REQ-010 SHALL have port rom_dout  input  LANES x DW  ROM data, valid one clock edge after rom_addr is sampled.
REQ-011 SHALL have port out_data  output  LANES x DW  held beat data.
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts beat when high with out_valid.
REQ-014 SHALL have port out_last  output  1  high with out_valid on the final beat of a burst.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on burst completion.

Function
REQ-017 SHALL implement states IDLE, ADDR, LATCH, PRESENT.
REQ-018 In IDLE, start=1 with beats!=0 SHALL set rom_addr<=base, store remaining=beats, go to ADDR.
REQ-019 In IDLE, start=1 with beats=0 SHALL pulse done next cycle, stay IDLE, issue no read.
REQ-020 start while not IDLE SHALL be ignored, with no effect on the burst in progress.
REQ-021 ADDR SHALL last one cycle (ROM samples rom_addr) and go to LATCH.
REQ-022 LATCH SHALL register out_data<=rom_dout, out_valid<=1, out_last<=(remaining==1), go to PRESENT.
REQ-023 out_valid=1 in the cycle after the start edge plus three edges (latency: start edge E0, out_valid high after E2).
REQ-024 In PRESENT, out_data, out_valid, out_last SHALL hold stable until out_ready=1.
REQ-025 On a PRESENT handshake with remaining>1, SHALL clear out_valid, set rom_addr<=rom_addr+LANES (mod 2^AW, wraps 48->0), decrement remaining, go to ADDR.
REQ-026 On a PRESENT handshake with remaining==1, SHALL clear out_valid and out_last, pulse done one cycle, go to IDLE.
REQ-027 Beat period with out_ready held high SHALL be 3 cycles; first beat 3 cycles after start.
REQ-028 out_data SHALL only change in LATCH; it retains the last beat after the burst ends.
REQ-029 beats values 5..7 SHALL be clamped to 4.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, rom_addr=0, out_data=0, out_valid=0, out_last=0, done=0, busy=0, remaining=0.
REQ-031 Reset mid-burst SHALL abandon the burst with no done pulse; first start after release begins a fresh burst.

Verification
REQ-032 base=0, beats=4, out_ready=1 -> rom_addr 0,16,32,48; 4 beats equal rom[0..15], rom[16..31], rom[32..47], rom[48..63]; out_last on beat 4; done once.
REQ-033 base=48, beats=2 -> rom_addr 48 then 0 (wrap); beat 2 equals rom[0..15].
REQ-034 beats=4, out_ready low 5 cycles on beat 2 -> out_data/out_valid stable throughout; rom_addr not advanced until handshake.
REQ-035 beats=0 -> no out_valid, done pulse one cycle after start, busy never high.
REQ-036 start pulsed again during burst -> ignored; exactly original beat count delivered.
REQ-037 rst_n low during PRESENT of beat 2 -> all outputs 0 asynchronously; no done; next start base=16, beats=1 -> single beat rom[16..31].
